// File: rtl/led_matrix_pkg.sv
// Shared geometry, scan state encoding and pixel-mapping helpers for the
// 5x5 RGB LED matrix scan controller.
package led_matrix_pkg;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int PIX  = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    DRIVE = 2'd3
  } scan_state_e;

  // Flat bit position of pixel (r, c) inside a frame word.
  function automatic int pix_idx(input int r, input int c);
    return r * COLS + c;
  endfunction

  // Column slice of one row from a flat frame word.
  function automatic logic [COLS-1:0] row_bits(input logic [PIX-1:0] frame, input int r);
    return COLS'(frame >> pix_idx(r, 0));
  endfunction

  // Counter width that can hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_cmp.sv
// Global-brightness PWM comparator. The count runs 0 .. 2^W-2 so that a
// level of 2^W-1 is on for every cycle and a level of 0 is never on.
module led_pwm_cmp
  import led_matrix_pkg::*;
#(
  parameter int BRIGHT_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_advance,
  input  logic [BRIGHT_W-1:0] i_level,
  output logic                o_pwm_on
);

  localparam logic [BRIGHT_W-1:0] CNT_LAST = BRIGHT_W'((1 << BRIGHT_W) - 2);

  logic [BRIGHT_W-1:0] r_pwm_cnt;
  logic [BRIGHT_W-1:0] w_cnt_nxt;

  // Next count: clear has priority, otherwise advance with wrap at CNT_LAST.
  always_comb begin
    w_cnt_nxt = r_pwm_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_advance) begin
      w_cnt_nxt = (r_pwm_cnt == CNT_LAST) ? '0 : r_pwm_cnt + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= w_cnt_nxt;
    end
  end

  // On/off for the count being loaded at this edge, so the parent can
  // register its column drive in the same cycle the count takes effect.
  assign o_pwm_on = (w_cnt_nxt < i_level);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan controller for the 5x5 RGB LED matrix.
//
// state | meaning
// IDLE  | outputs off, waiting for enable
// LOAD  | one cycle: latch frame + brightness, pulse frame_start
// BLANK | all outputs off ahead of each row (dead time)
// DRIVE | one row enabled, columns gated by PWM
//
// All outputs are registered in step with the state: the cycle the state
// register shows LOAD is the cycle frame_start is high, and so on.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROW_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BRIGHT_W     = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [PIX-1:0]      i_r,
  input  logic [PIX-1:0]      i_g,
  input  logic [PIX-1:0]      i_b,
  input  logic [BRIGHT_W-1:0] i_brightness,
  output logic [ROWS-1:0]     o_row_sel,
  output logic [COLS-1:0]     o_col_r,
  output logic [COLS-1:0]     o_col_g,
  output logic [COLS-1:0]     o_col_b,
  output logic                o_frame_start,
  output logic                o_busy
);

  localparam int RCW = cnt_w(ROW_CYCLES);
  localparam int BCW = cnt_w(BLANK_CYCLES + 1);
  localparam int RIW = cnt_w(ROWS);

  localparam logic [RCW-1:0] ROW_CNT_LAST = RCW'(ROW_CYCLES - 1);
  localparam logic [BCW-1:0] BLANK_LAST   = BCW'(BLANK_CYCLES - 1);
  localparam logic [RIW-1:0] ROW_LAST     = RIW'(ROWS - 1);
  localparam bit             NO_BLANK     = (BLANK_CYCLES == 0);

  scan_state_e         r_state;
  logic [RIW-1:0]      r_row_idx;
  logic [RCW-1:0]      r_row_cnt;
  logic [BCW-1:0]      r_blank_cnt;
  logic [PIX-1:0]      r_sh_r;
  logic [PIX-1:0]      r_sh_g;
  logic [PIX-1:0]      r_sh_b;
  logic [BRIGHT_W-1:0] r_bright;
  logic [ROWS-1:0]     r_row_sel;
  logic [COLS-1:0]     r_col_r;
  logic [COLS-1:0]     r_col_g;
  logic [COLS-1:0]     r_col_b;
  logic                r_frame_start;
  logic                r_busy;

  logic [PIX-1:0]      w_src_r;
  logic [PIX-1:0]      w_src_g;
  logic [PIX-1:0]      w_src_b;
  logic [BRIGHT_W-1:0] w_level;
  logic                w_row_end;
  logic                w_last_row;
  logic                w_row_start;
  logic                w_drive_stay;
  logic                w_drive_enter;
  logic [RIW-1:0]      w_next_row;
  logic [RIW-1:0]      w_tgt_row;
  logic [ROWS-1:0]     w_tgt_sel;
  logic [COLS-1:0]     w_tgt_col_r;
  logic [COLS-1:0]     w_tgt_col_g;
  logic [COLS-1:0]     w_tgt_col_b;
  logic                w_pwm_on;

  // Sequencing decisions for this cycle. While in LOAD the shadow is being
  // written at this edge, so a zero-blank entry into row 0 reads the live
  // inputs instead of the not-yet-updated shadow.
  always_comb begin
    w_src_r = r_sh_r;
    w_src_g = r_sh_g;
    w_src_b = r_sh_b;
    w_level = r_bright;
    if (r_state == LOAD) begin
      w_src_r = i_r;
      w_src_g = i_g;
      w_src_b = i_b;
      w_level = i_brightness;
    end
    w_row_end     = (r_state == DRIVE) && (r_row_cnt == '0);
    w_last_row    = (r_row_idx == ROW_LAST);
    w_row_start   = (r_state == LOAD) || (w_row_end && !w_last_row);
    w_next_row    = (r_state == LOAD) ? '0 : r_row_idx + 1'b1;
    w_drive_stay  = (r_state == DRIVE) && !w_row_end;
    w_drive_enter = ((r_state == BLANK) && (r_blank_cnt == '0)) ||
                    (w_row_start && NO_BLANK);
    w_tgt_row     = w_row_start ? w_next_row : r_row_idx;
    w_tgt_sel     = ROWS'(1) << w_tgt_row;
    w_tgt_col_r   = row_bits(w_src_r, int'(w_tgt_row)) & {COLS{w_pwm_on}};
    w_tgt_col_g   = row_bits(w_src_g, int'(w_tgt_row)) & {COLS{w_pwm_on}};
    w_tgt_col_b   = row_bits(w_src_b, int'(w_tgt_row)) & {COLS{w_pwm_on}};
  end

  led_pwm_cmp #(
    .BRIGHT_W (BRIGHT_W)
  ) u_pwm (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_drive_enter),
    .i_advance (w_drive_stay),
    .i_level   (w_level),
    .o_pwm_on  (w_pwm_on)
  );

  // Scan FSM with registered row/column drive and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_row_idx     <= '0;
      r_row_cnt     <= '0;
      r_blank_cnt   <= '0;
      r_sh_r        <= '0;
      r_sh_g        <= '0;
      r_sh_b        <= '0;
      r_bright      <= '0;
      r_row_sel     <= '0;
      r_col_r       <= '0;
      r_col_g       <= '0;
      r_col_b       <= '0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (r_state == LOAD) begin
        r_sh_r   <= i_r;
        r_sh_g   <= i_g;
        r_sh_b   <= i_b;
        r_bright <= i_brightness;
      end
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state       <= LOAD;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        default: begin
          if (w_drive_enter) begin
            r_state   <= DRIVE;
            r_row_idx <= w_tgt_row;
            r_row_cnt <= ROW_CNT_LAST;
            r_row_sel <= w_tgt_sel;
            r_col_r   <= w_tgt_col_r;
            r_col_g   <= w_tgt_col_g;
            r_col_b   <= w_tgt_col_b;
          end else if (w_row_start) begin
            r_state     <= BLANK;
            r_row_idx   <= w_tgt_row;
            r_blank_cnt <= BLANK_LAST;
            r_row_sel   <= '0;
            r_col_r     <= '0;
            r_col_g     <= '0;
            r_col_b     <= '0;
          end else if (w_drive_stay) begin
            r_row_cnt <= r_row_cnt - 1'b1;
            r_col_r   <= w_tgt_col_r;
            r_col_g   <= w_tgt_col_g;
            r_col_b   <= w_tgt_col_b;
          end else if (r_state == BLANK) begin
            r_blank_cnt <= r_blank_cnt - 1'b1;
          end else if (w_row_end) begin
            // Last row finished: enable is only honoured here, so a frame
            // is never cut short.
            r_row_sel <= '0;
            r_col_r   <= '0;
            r_col_g   <= '0;
            r_col_b   <= '0;
            if (i_enable) begin
              r_state       <= LOAD;
              r_frame_start <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_row_sel     = r_row_sel;
  assign o_col_r       = r_col_r;
  assign o_col_g       = r_col_g;
  assign o_col_b       = r_col_b;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: directed scenarios followed by
// randomized traffic, all compared against a frame-position reference model.
module tb_led_matrix_scan;
  import led_matrix_pkg::*;

  localparam int RC  = 30;
  localparam int BC  = 2;
  localparam int BW  = 4;
  localparam int SEG = BC + RC;
  localparam int FL  = 1 + ROWS * SEG;
  localparam int PER = (1 << BW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [PIX-1:0]  r_in, g_in, b_in;
  logic [BW-1:0]   br;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_r, col_g, col_b;
  logic            frame_start, busy;

  always #5 clk = ~clk;

  led_matrix_scan #(
    .ROW_CYCLES   (RC),
    .BLANK_CYCLES (BC),
    .BRIGHT_W     (BW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (en),
    .i_r           (r_in),
    .i_g           (g_in),
    .i_b           (b_in),
    .i_brightness  (br),
    .o_row_sel     (row_sel),
    .o_col_r       (col_r),
    .o_col_g       (col_g),
    .o_col_b       (col_b),
    .o_frame_start (frame_start),
    .o_busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position within the frame (0 = LOAD cycle).
  bit             m_act   = 1'b0;
  bit             m_valid = 1'b0;
  int             m_pos   = 0;
  logic [PIX-1:0] m_r = '0, m_g = '0, m_b = '0;
  int             m_br = 0;

  function automatic bit pix(input logic [PIX-1:0] f, input int k, input int c);
    return ((f >> pix_idx(k, c)) & PIX'(1)) != '0;
  endfunction

  function automatic logic [21:0] model_out();
    logic [4:0] rs, cr, cg, cb;
    bit fs, bz, on;
    int p, k, q, d;
    rs = '0; cr = '0; cg = '0; cb = '0; fs = 1'b0; bz = 1'b0;
    if (m_act) begin
      bz = 1'b1;
      if (m_pos == 0) begin
        fs = 1'b1;
      end else begin
        p = m_pos - 1;
        k = p / SEG;
        q = p % SEG;
        if (q >= BC) begin
          d  = q - BC;
          rs = 5'(1 << k);
          on = (d % PER) < m_br;
          for (int c = 0; c < COLS; c++) begin
            if (on && pix(m_r, k, c)) cr = cr | 5'(1 << c);
            if (on && pix(m_g, k, c)) cg = cg | 5'(1 << c);
            if (on && pix(m_b, k, c)) cb = cb | 5'(1 << c);
          end
        end
      end
    end
    return {rs, cr, cg, cb, fs, bz};
  endfunction

  // Expected col_g[0]-high cycles over a full frame of the latched data.
  function automatic int exp_g_cnt();
    int n, per_row;
    per_row = 0;
    for (int d = 0; d < RC; d++) if ((d % PER) < m_br) per_row++;
    n = 0;
    for (int k = 0; k < ROWS; k++) if (pix(m_g, k, 0)) n += per_row;
    return n;
  endfunction

  int              n_cyc   = 0;
  int              last_fs = -1;
  int              fs_gap  = 0;
  int              gcnt    = 0;
  logic [ROWS-1:0] last_row = '0;
  int              zrun    = 0;

  task automatic cyc();
    logic [21:0] obs;
    @(negedge clk);
    n_cyc++;
    if (m_valid) begin
      obs = {row_sel, col_r, col_g, col_b, frame_start, busy};
      chk("outputs", 32'(obs), 32'(model_out()));
      chk("row_onehot", 32'($countones(row_sel) <= 1), 32'd1);
      if (row_sel == '0 && col_r == '0 && col_g == '0 && col_b == '0) begin
        zrun++;
      end else begin
        if (row_sel != '0 && last_row != '0 && row_sel != last_row)
          chk("blank_gap", 32'(zrun >= BC), 32'd1);
        if (row_sel != '0) last_row = row_sel;
        zrun = 0;
      end
      if (frame_start) begin
        if (last_fs >= 0) begin
          fs_gap = n_cyc - last_fs;
          if (fs_gap == FL) chk("g_duty", 32'(gcnt), 32'(exp_g_cnt()));
        end
        last_fs = n_cyc;
        gcnt    = 0;
      end else if (col_g[0]) begin
        gcnt++;
      end
    end
    @(posedge clk);
    if (rst) begin
      m_act = 1'b0; m_pos = 0; m_valid = 1'b1;
      last_fs = -1; last_row = '0; zrun = 0;
    end else if (!m_act) begin
      if (en) begin m_act = 1'b1; m_pos = 0; end
    end else if (m_pos == 0) begin
      m_r = r_in; m_g = g_in; m_b = b_in; m_br = int'(br); m_pos = 1;
    end else if (m_pos == FL - 1) begin
      if (en) m_pos = 0;
      else m_act = 1'b0;
    end else begin
      m_pos++;
    end
    #1;
  endtask

  task automatic wait_row(input logic [ROWS-1:0] want, input string tag);
    int t;
    t = 0;
    while (row_sel != want && t < 2 * FL) begin cyc(); t++; end
    chk(tag, 32'(row_sel), 32'(want));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; r_in = '0; g_in = '0; b_in = '0; br = 4'd15;
    repeat (3) cyc();
    chk("reset_rowsel", 32'(row_sel), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Red on row 0 only, full brightness; measure frame period.
    rst = 1'b0; en = 1'b1; r_in = 25'h000001F;
    cyc();
    chk("first_fs", 32'(frame_start), 32'd1);
    repeat (2 * FL + 5) cyc();
    chk("frame_period", 32'(fs_gap), 32'(FL));

    // Green PWM at 5/15, then brightness 0.
    r_in = '0; g_in = '1; br = 4'd5;
    repeat (2 * FL + 2) cyc();
    br = 4'd0;
    repeat (2 * FL + 2) cyc();

    // Blue changes mid-row-2: must not appear until the next frame.
    br = 4'd15; g_in = '0; b_in = '0;
    wait_row(5'b00100, "reach_row2");
    repeat (5) cyc();
    b_in = '1;
    repeat (2 * FL) cyc();

    // Drop enable during row 1: frame completes, then idle.
    wait_row(5'b00010, "reach_row1");
    en = 1'b0;
    repeat (FL + 20) cyc();
    chk("idle_busy", 32'(busy), 32'd0);
    en = 1'b1;
    cyc();
    chk("reload_fs", 32'(frame_start), 32'd1);

    // Reset mid-drive of row 3, then restart.
    wait_row(5'b01000, "reach_row3");
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_rowsel", 32'(row_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc();
    chk("restart_fs", 32'(frame_start), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r_in = PIX'($urandom); g_in = PIX'($urandom); b_in = PIX'($urandom);
        br   = BW'($urandom);
      end
      if ($urandom_range(0, 299) == 0) en = ~en;
      rst = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst = 1'b0;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
